// File: rtl/edge_bit_counter_if.sv
// -----------------------------------------------------------------------------
// edge_bit_counter_if
//   Bundles the signals exchanged between the UART RX FSM and the edge/bit
//   timing counter.
//
//   Signals:
//     enable   : count enable, high for the whole frame (driven by the FSM)
//     bit_cnt  : bit index within the frame, 0..FRAME_BITS-1 (from counter)
//     edge_cnt : oversampling edge within the bit, 0..PRESCALE-1 (from counter)
//
//   Modports:
//     master : RX FSM / sampler side (drives enable, observes the counts)
//     slave  : counter side (observes enable, drives the counts)
// -----------------------------------------------------------------------------
interface edge_bit_counter_if;
  logic       enable;
  logic [3:0] bit_cnt;
  logic [3:0] edge_cnt;

  modport master (
    output enable,
    input  bit_cnt,
    input  edge_cnt
  );

  modport slave (
    input  enable,
    output bit_cnt,
    output edge_cnt
  );
endinterface

// File: rtl/edge_bit_counter.sv
// -----------------------------------------------------------------------------
// edge_bit_counter
//   Timing counter for the UART receiver. edge_cnt counts oversampling clock
//   edges inside one serial bit; bit_cnt counts bit positions inside a frame.
//   While enable is high the pair advances once per clock and wraps after
//   PRESCALE*FRAME_BITS cycles; while enable is low both are cleared on every
//   clock edge.
//
//   Parameters:
//     PRESCALE   : oversampling clocks per bit, 2..16
//     FRAME_BITS : bits per frame, 1..16
//
//   Ports:
//     clk : oversampling clock, rising-edge active
//     rst : asynchronous active-low reset, clears both counters
//     bus : slave side of edge_bit_counter_if (enable in, counts out)
// -----------------------------------------------------------------------------
module edge_bit_counter #(
  parameter int PRESCALE   = 16,
  parameter int FRAME_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  edge_bit_counter_if.slave    bus
);

  localparam logic [3:0] EDGE_LAST = 4'(PRESCALE - 1);
  localparam logic [3:0] BIT_LAST  = 4'(FRAME_BITS - 1);

  logic [3:0] edge_q, edge_d;
  logic [3:0] bit_q,  bit_d;

  // Next-state logic. Wrapping is done by comparison against the limits rather
  // than by 4-bit overflow, so any parameter setting stays in range. Using
  // ">=" / ">" means a counter that somehow holds an out-of-range value is
  // pulled back to 0 on the next enabled edge.
  always_comb begin
    edge_d = 4'd0;
    bit_d  = 4'd0;
    if (bus.enable) begin
      if (edge_q >= EDGE_LAST) begin
        edge_d = 4'd0;
        bit_d  = (bit_q >= BIT_LAST) ? 4'd0 : bit_q + 4'd1;
      end else begin
        edge_d = edge_q + 4'd1;
        bit_d  = (bit_q > BIT_LAST) ? 4'd0 : bit_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_q <= 4'd0;
      bit_q  <= 4'd0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign bus.edge_cnt = edge_q;
  assign bus.bit_cnt  = bit_q;

endmodule

// File: tb/tb_edge_bit_counter.sv
// -----------------------------------------------------------------------------
// tb_edge_bit_counter
//   Self-checking bench for edge_bit_counter. Two instances run side by side:
//   the default configuration (16 x 10) and an override (8 x 11). Both share
//   clk, rst and enable. The reference model tracks each counter as a single
//   position within the frame (0 .. PRESCALE*FRAME_BITS-1); the expected
//   edge_cnt/bit_cnt are that position's remainder/quotient by PRESCALE.
// -----------------------------------------------------------------------------
module tb_edge_bit_counter;

  localparam int PA = 16;
  localparam int FA = 10;
  localparam int PB = 8;
  localparam int FB = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // model positions within the frame
  int pos_a = 0;
  int pos_b = 0;

  edge_bit_counter_if bus_a ();
  edge_bit_counter_if bus_b ();

  assign bus_a.enable = en;
  assign bus_b.enable = en;

  edge_bit_counter #(.PRESCALE(PA), .FRAME_BITS(FA)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  edge_bit_counter #(.PRESCALE(PB), .FRAME_BITS(FB)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  always #5 clk = ~clk;

  // One clock: update the model from the inputs seen at the edge, then move
  // 1 time unit past the edge so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      pos_a = 0;
      pos_b = 0;
    end else if (en) begin
      pos_a = (pos_a + 1) % (PA * FA);
      pos_b = (pos_b + 1) % (PB * FB);
    end else begin
      pos_a = 0;
      pos_b = 0;
    end
    #1;
    $display("t=%0t rst=%b en=%b a(bit/edge)=%0d/%0d b(bit/edge)=%0d/%0d",
             $time, rst, en, bus_a.bit_cnt, bus_a.edge_cnt,
             bus_b.bit_cnt, bus_b.edge_cnt);
  endtask

  task automatic clear();
    en = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en  = 1'b1;
    #1;
    n_checks++;
    if (bus_a.edge_cnt !== 4'd0 || bus_a.bit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_initial: got bit/edge %0d/%0d, expected 0/0",
               bus_a.bit_cnt, bus_a.edge_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (bus_a.edge_cnt !== 4'd0 || bus_a.bit_cnt !== 4'd0 ||
          bus_b.edge_cnt !== 4'd0 || bus_b.bit_cnt !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_hold: got a=%0d/%0d b=%0d/%0d, expected 0/0",
                 bus_a.bit_cnt, bus_a.edge_cnt, bus_b.bit_cnt, bus_b.edge_cnt);
      end
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (bus_a.edge_cnt !== 4'd1 || bus_a.bit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_release: got bit/edge %0d/%0d, expected 0/1",
               bus_a.bit_cnt, bus_a.edge_cnt);
    end
  endtask

  task automatic test_bit_roll();
    clear();
    en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      n_checks++;
      if (bus_a.edge_cnt !== 4'(k % 16) || bus_a.bit_cnt !== 4'(k / 16)) begin
        n_fail++;
        $display("FAIL bit_roll cycle %0d: got bit/edge %0d/%0d, expected %0d/%0d",
                 k, bus_a.bit_cnt, bus_a.edge_cnt, k / 16, k % 16);
      end
    end
  endtask

  task automatic test_mid_disable();
    clear();
    en = 1'b1;
    repeat (10) step();
    n_checks++;
    if (bus_a.edge_cnt !== 4'd10 || bus_a.bit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_disable_run: got bit/edge %0d/%0d, expected 0/10",
               bus_a.bit_cnt, bus_a.edge_cnt);
    end
    en = 1'b0;
    step();
    n_checks++;
    if (bus_a.edge_cnt !== 4'd0 || bus_a.bit_cnt !== 4'd0 ||
        bus_b.edge_cnt !== 4'd0 || bus_b.bit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_disable_clear: got a=%0d/%0d b=%0d/%0d, expected 0/0",
               bus_a.bit_cnt, bus_a.edge_cnt, bus_b.bit_cnt, bus_b.edge_cnt);
    end
    en = 1'b1;
    step();
    n_checks++;
    if (bus_a.edge_cnt !== 4'd1 || bus_a.bit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_disable_resume: got bit/edge %0d/%0d, expected 0/1",
               bus_a.bit_cnt, bus_a.edge_cnt);
    end
  endtask

  task automatic test_frame_wrap();
    clear();
    en = 1'b1;
    for (int k = 1; k <= 161; k++) begin
      step();
      n_checks++;
      if (bus_a.edge_cnt !== 4'(pos_a % PA) || bus_a.bit_cnt !== 4'(pos_a / PA)) begin
        n_fail++;
        $display("FAIL frame_wrap cycle %0d: got bit/edge %0d/%0d, expected %0d/%0d",
                 k, bus_a.bit_cnt, bus_a.edge_cnt, pos_a / PA, pos_a % PA);
      end
      if (k == 159) begin
        n_checks++;
        if (bus_a.edge_cnt !== 4'd15 || bus_a.bit_cnt !== 4'd9) begin
          n_fail++;
          $display("FAIL frame_last: got bit/edge %0d/%0d, expected 9/15",
                   bus_a.bit_cnt, bus_a.edge_cnt);
        end
      end
      if (k == 160) begin
        n_checks++;
        if (bus_a.edge_cnt !== 4'd0 || bus_a.bit_cnt !== 4'd0) begin
          n_fail++;
          $display("FAIL frame_wrapped: got bit/edge %0d/%0d, expected 0/0",
                   bus_a.bit_cnt, bus_a.edge_cnt);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    clear();
    en = 1'b1;
    repeat (4 * 16 + 7) step();
    n_checks++;
    if (bus_a.edge_cnt !== 4'd7 || bus_a.bit_cnt !== 4'd4) begin
      n_fail++;
      $display("FAIL async_setup: got bit/edge %0d/%0d, expected 4/7",
               bus_a.bit_cnt, bus_a.edge_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    pos_a = 0;
    pos_b = 0;
    #1;
    n_checks++;
    if (bus_a.edge_cnt !== 4'd0 || bus_a.bit_cnt !== 4'd0 ||
        bus_b.edge_cnt !== 4'd0 || bus_b.bit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset: got a=%0d/%0d b=%0d/%0d, expected 0/0 before clk edge",
               bus_a.bit_cnt, bus_a.edge_cnt, bus_b.bit_cnt, bus_b.edge_cnt);
    end
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if (bus_a.edge_cnt !== 4'd1 || bus_a.bit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL async_release: got bit/edge %0d/%0d, expected 0/1",
               bus_a.bit_cnt, bus_a.edge_cnt);
    end
  endtask

  task automatic test_param_override();
    int max_edge;
    clear();
    en = 1'b1;
    max_edge = 0;
    for (int k = 1; k <= 88; k++) begin
      step();
      if (int'(bus_b.edge_cnt) > max_edge) max_edge = int'(bus_b.edge_cnt);
      n_checks++;
      if (bus_b.edge_cnt !== 4'((k % 88) % 8) || bus_b.bit_cnt !== 4'((k % 88) / 8)) begin
        n_fail++;
        $display("FAIL override cycle %0d: got bit/edge %0d/%0d, expected %0d/%0d",
                 k, bus_b.bit_cnt, bus_b.edge_cnt, (k % 88) / 8, (k % 88) % 8);
      end
    end
    n_checks++;
    if (max_edge > 7) begin
      n_fail++;
      $display("FAIL override_edge_max: got %0d, required <= 7", max_edge);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      en  = ($urandom_range(0, 19) != 0);
      rst = ($urandom_range(0, 99) != 0);
      step();
      n_checks++;
      if (bus_a.edge_cnt !== 4'(pos_a % PA) || bus_a.bit_cnt !== 4'(pos_a / PA) ||
          bus_b.edge_cnt !== 4'(pos_b % PB) || bus_b.bit_cnt !== 4'(pos_b / PB)) begin
        n_fail++;
        $display("FAIL random cycle %0d: got a=%0d/%0d b=%0d/%0d, expected a=%0d/%0d b=%0d/%0d",
                 k, bus_a.bit_cnt, bus_a.edge_cnt, bus_b.bit_cnt, bus_b.edge_cnt,
                 pos_a / PA, pos_a % PA, pos_b / PB, pos_b % PB);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_bit_roll();
    test_mid_disable();
    test_frame_wrap();
    test_async_reset();
    test_param_override();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
